// File: rtl/cmd_arb_pkg.sv
// rtl/cmd_arb_pkg.sv - shared command codes and FSM encodings for cmd_arb
package cmd_arb_pkg;

    localparam logic [7:0] C_TARGET_TAP      = 8'h01;
    localparam logic [7:0] C_TAP_SET_GT      = 8'h03;
    localparam logic [7:0] C_TARGET_ARB      = 8'hF0;
    localparam logic [7:0] C_ARB_RSP_TIMEOUT = 8'h01;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_PRESENT  = 2'd1;
    localparam logic [1:0] ST_WAIT_RSP = 2'd2;
    localparam logic [1:0] ST_WRITE    = 2'd3;

    function automatic logic [31:0] arb_err_word(input logic [7:0] target, input logic [7:0] code);
        return {target, code, 16'h0000};
    endfunction

endpackage

// File: rtl/cmd_arb_rr_arb2.sv
// rtl/cmd_arb_rr_arb2.sv - two-way round-robin pick with registered last-granted pointer
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_req,
    input  logic       i_update,
    input  logic       i_upd_idx,
    output logic       o_valid,
    output logic       o_idx
);

    logic r_last;

    // Pointer starts at 1 so source 0 wins the first contested pick.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= 1'b1;
        end else if (i_update) begin
            r_last <= i_upd_idx;
        end
    end

    always_comb begin
        o_valid = |i_req;
        if (&i_req) begin
            o_idx = ~r_last;
        end else begin
            o_idx = i_req[1];
        end
    end

endmodule

// File: rtl/cmd_arb.sv
// rtl/cmd_arb.sv - two-source round-robin command arbiter in front of fcr with response timeout
module cmd_arb
    import cmd_arb_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] s0_cmd_data,
    input  logic              s0_cmd_waitreq,
    output logic              s0_cmd_rdreq,
    output logic [DATA_W-1:0] s0_rsp_data,
    output logic              s0_rsp_wrreq,
    input  logic              s0_rsp_waitreq,
    input  logic [DATA_W-1:0] s1_cmd_data,
    input  logic              s1_cmd_waitreq,
    output logic              s1_cmd_rdreq,
    output logic [DATA_W-1:0] s1_rsp_data,
    output logic              s1_rsp_wrreq,
    input  logic              s1_rsp_waitreq,
    output logic [DATA_W-1:0] fcr_cmd_data,
    output logic              fcr_cmd_waitreq,
    input  logic              fcr_cmd_rdreq,
    input  logic [DATA_W-1:0] fcr_rsp_data,
    input  logic              fcr_rsp_wrreq,
    output logic              fcr_rsp_waitreq,
    output logic              grant,
    output logic              busy,
    output logic              err_timeout
);

    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0]     C_CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [DATA_W-1:0] C_ERR_WORD = DATA_W'(arb_err_word(C_TARGET_ARB, C_ARB_RSP_TIMEOUT));

    logic [1:0]        r_state;
    logic              r_grant;
    logic [DATA_W-1:0] r_hold;
    logic [DATA_W-1:0] r_rsp;
    logic [CW-1:0]     r_cnt;
    logic              r_err;

    logic w_req_valid;
    logic w_req_idx;
    logic w_pop;
    logic w_wr;
    logic w_sink_wait;

    rr_arb2 u_rr_arb2 (
        .clk       (clk),
        .rst       (rst),
        .i_req     ({~s1_cmd_waitreq, ~s0_cmd_waitreq}),
        .i_update  (w_wr),
        .i_upd_idx (r_grant),
        .o_valid   (w_req_valid),
        .o_idx     (w_req_idx)
    );

    // Strobes are gated by rst so a reset cycle never pops or writes a FIFO.
    assign w_sink_wait = r_grant ? s1_rsp_waitreq : s0_rsp_waitreq;
    assign w_pop       = (r_state == ST_IDLE) && w_req_valid && !rst;
    assign w_wr        = (r_state == ST_WRITE) && !w_sink_wait && !rst;

    assign s0_cmd_rdreq    = w_pop && !w_req_idx;
    assign s1_cmd_rdreq    = w_pop && w_req_idx;
    assign s0_rsp_wrreq    = w_wr && !r_grant;
    assign s1_rsp_wrreq    = w_wr && r_grant;
    assign s0_rsp_data     = r_rsp;
    assign s1_rsp_data     = r_rsp;
    assign fcr_cmd_data    = r_hold;
    assign fcr_cmd_waitreq = (r_state != ST_PRESENT);
    assign fcr_rsp_waitreq = (r_state != ST_WAIT_RSP);
    assign grant           = r_grant;
    assign busy            = (r_state != ST_IDLE);
    assign err_timeout     = r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_grant <= 1'b0;
            r_hold  <= '0;
            r_rsp   <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_req_valid) begin
                        r_grant <= w_req_idx;
                        r_hold  <= w_req_idx ? s1_cmd_data : s0_cmd_data;
                        r_state <= ST_PRESENT;
                    end
                end
                ST_PRESENT: begin
                    if (fcr_cmd_rdreq) begin
                        r_cnt   <= '0;
                        r_state <= ST_WAIT_RSP;
                    end
                end
                ST_WAIT_RSP: begin
                    r_cnt <= r_cnt + CW'(1);
                    // A real response beats expiry in the same cycle.
                    if (fcr_rsp_wrreq) begin
                        r_rsp   <= fcr_rsp_data;
                        r_state <= ST_WRITE;
                    end else if (r_cnt == C_CNT_LAST) begin
                        r_rsp   <= C_ERR_WORD;
                        r_err   <= 1'b1;
                        r_state <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (!w_sink_wait) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cmd_arb.sv
// tb/tb_cmd_arb.sv - directed self-checking bench for cmd_arb with a transaction-level reference model
module tb_cmd_arb;

    localparam int DW  = 32;
    localparam int TMO = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] s0_cmd_data, s1_cmd_data;
    logic          s0_cmd_waitreq, s1_cmd_waitreq;
    logic          s0_cmd_rdreq, s1_cmd_rdreq;
    logic [DW-1:0] s0_rsp_data, s1_rsp_data;
    logic          s0_rsp_wrreq, s1_rsp_wrreq;
    logic          s0_rsp_waitreq, s1_rsp_waitreq;
    logic [DW-1:0] fcr_cmd_data;
    logic          fcr_cmd_waitreq;
    logic          fcr_cmd_rdreq;
    logic [DW-1:0] fcr_rsp_data;
    logic          fcr_rsp_wrreq;
    logic          fcr_rsp_waitreq;
    logic          grant, busy, err_timeout;

    cmd_arb #(.DATA_W(DW), .TIMEOUT(TMO)) dut (
        .clk             (clk),
        .rst             (rst),
        .s0_cmd_data     (s0_cmd_data),
        .s0_cmd_waitreq  (s0_cmd_waitreq),
        .s0_cmd_rdreq    (s0_cmd_rdreq),
        .s0_rsp_data     (s0_rsp_data),
        .s0_rsp_wrreq    (s0_rsp_wrreq),
        .s0_rsp_waitreq  (s0_rsp_waitreq),
        .s1_cmd_data     (s1_cmd_data),
        .s1_cmd_waitreq  (s1_cmd_waitreq),
        .s1_cmd_rdreq    (s1_cmd_rdreq),
        .s1_rsp_data     (s1_rsp_data),
        .s1_rsp_wrreq    (s1_rsp_wrreq),
        .s1_rsp_waitreq  (s1_rsp_waitreq),
        .fcr_cmd_data    (fcr_cmd_data),
        .fcr_cmd_waitreq (fcr_cmd_waitreq),
        .fcr_cmd_rdreq   (fcr_cmd_rdreq),
        .fcr_rsp_data    (fcr_rsp_data),
        .fcr_rsp_wrreq   (fcr_rsp_wrreq),
        .fcr_rsp_waitreq (fcr_rsp_waitreq),
        .grant           (grant),
        .busy            (busy),
        .err_timeout     (err_timeout)
    );

    always #5 clk = ~clk;

    int cyc, total, bad;

    // Reference model: which transaction phase the arbiter must be in and what it holds.
    int          m_phase;   // 0 idle, 1 command offered, 2 awaiting reply, 3 delivering reply
    logic        m_grant, m_last, m_errp;
    logic [31:0] m_hold, m_rsp;
    int          m_wait_cycles;

    logic [31:0] q0[$], q1[$];
    logic        p0, p1;

    int          rd_delay, rsp_delay, pcnt, wcnt, rd_cyc, rsp_cyc;
    logic        silent, stray, stall_en, stall_armed;
    logic [31:0] fcr_latched;

    int          pop_q[$], wr_src_q[$], wr_cyc_q[$], err_q[$];
    logic [31:0] wr_data_q[$];

    function automatic logic [31:0] resp_fn(input logic [31:0] cmd);
        return {16'h0000, cmd[15:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic check_cycle();
        logic e_pop0, e_pop1, e_wr0, e_wr1;
        e_pop0 = 1'b0;
        e_pop1 = 1'b0;
        if (m_phase == 0 && !rst) begin
            if (!s0_cmd_waitreq && !s1_cmd_waitreq) begin
                if (m_last) e_pop0 = 1'b1;
                else        e_pop1 = 1'b1;
            end else if (!s0_cmd_waitreq) begin
                e_pop0 = 1'b1;
            end else if (!s1_cmd_waitreq) begin
                e_pop1 = 1'b1;
            end
        end
        e_wr0 = (m_phase == 3) && !rst && !m_grant && !s0_rsp_waitreq;
        e_wr1 = (m_phase == 3) && !rst &&  m_grant && !s1_rsp_waitreq;

        chk("s0_cmd_rdreq", s0_cmd_rdreq, e_pop0);
        chk("s1_cmd_rdreq", s1_cmd_rdreq, e_pop1);
        chk("s0_rsp_wrreq", s0_rsp_wrreq, e_wr0);
        chk("s1_rsp_wrreq", s1_rsp_wrreq, e_wr1);
        chk("busy", busy, m_phase != 0);
        chk("grant", grant, m_grant);
        chk("err_timeout", err_timeout, m_errp);
        chk("fcr_cmd_waitreq", fcr_cmd_waitreq, m_phase != 1);
        chk("fcr_rsp_waitreq", fcr_rsp_waitreq, m_phase != 2);
        chk("fcr_cmd_data", fcr_cmd_data, m_hold);
        if (m_phase == 3) chk("rsp_data", m_grant ? s1_rsp_data : s0_rsp_data, m_rsp);

        p0 = s0_cmd_rdreq;
        p1 = s1_cmd_rdreq;
        if (s0_cmd_rdreq || s1_cmd_rdreq) pop_q.push_back(cyc);
        if (s0_rsp_wrreq) begin wr_src_q.push_back(0); wr_data_q.push_back(s0_rsp_data); wr_cyc_q.push_back(cyc); end
        if (s1_rsp_wrreq) begin wr_src_q.push_back(1); wr_data_q.push_back(s1_rsp_data); wr_cyc_q.push_back(cyc); end
        if (err_timeout) err_q.push_back(cyc);

        if (rst) begin
            m_phase = 0; m_grant = 1'b0; m_last = 1'b1; m_errp = 1'b0;
            m_hold = '0; m_rsp = '0; m_wait_cycles = 0;
        end else begin
            m_errp = 1'b0;
            case (m_phase)
                0: if (e_pop0 || e_pop1) begin
                    m_grant = e_pop1;
                    m_hold  = e_pop1 ? s1_cmd_data : s0_cmd_data;
                    m_phase = 1;
                end
                1: if (fcr_cmd_rdreq) begin
                    m_phase = 2;
                    m_wait_cycles = 0;
                end
                2: begin
                    if (fcr_rsp_wrreq) begin
                        m_rsp = fcr_rsp_data;
                        m_phase = 3;
                    end else if (m_wait_cycles == TMO - 1) begin
                        m_rsp = 32'hF001_0000;
                        m_errp = 1'b1;
                        m_phase = 3;
                    end
                    m_wait_cycles++;
                end
                default: if (e_wr0 || e_wr1) begin
                    m_last = m_grant;
                    m_phase = 0;
                end
            endcase
        end
    endtask

    task automatic drive_fifos();
        s0_cmd_waitreq = (q0.size() == 0);
        s1_cmd_waitreq = (q1.size() == 0);
        s0_cmd_data    = (q0.size() != 0) ? q0[0] : 32'h0;
        s1_cmd_data    = (q1.size() != 0) ? q1[0] : 32'h0;
    endtask

    task automatic drive_after_edge();
        if (p0 && q0.size() != 0) void'(q0.pop_front());
        if (p1 && q1.size() != 0) void'(q1.pop_front());
        fcr_cmd_rdreq = 1'b0;
        fcr_rsp_wrreq = 1'b0;
        fcr_rsp_data  = {16'hDEAD, cyc[15:0]};
        if (!fcr_cmd_waitreq) begin
            if (pcnt == rd_delay) begin
                fcr_cmd_rdreq = 1'b1;
                fcr_latched   = fcr_cmd_data;
                rd_cyc        = cyc;
            end
            pcnt++;
        end else begin
            pcnt = 0;
        end
        if (!fcr_rsp_waitreq) begin
            if (!silent && wcnt == rsp_delay) begin
                fcr_rsp_wrreq = 1'b1;
                fcr_rsp_data  = resp_fn(fcr_latched);
                rsp_cyc       = cyc;
                if (stall_en) stall_armed = 1'b1;
            end
            wcnt++;
        end else begin
            wcnt = 0;
            if (stray) fcr_rsp_wrreq = 1'b1;
        end
        if (stall_en && stall_armed && cyc >= rsp_cyc + 21) begin
            stall_en    = 1'b0;
            stall_armed = 1'b0;
        end
        s0_rsp_waitreq = 1'b0;
        s1_rsp_waitreq = stall_en;
        drive_fifos();
    endtask

    task automatic tick();
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        #1;
        cyc++;
        drive_after_edge();
    endtask

    task automatic run_idle(input int bound);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!(m_phase == 0 && q0.size() == 0 && q1.size() == 0) && n < bound);
        chk("run_bound", n < bound, 1);
        tick();
        tick();
    endtask

    task automatic clear_logs();
        pop_q.delete(); wr_src_q.delete(); wr_data_q.delete(); wr_cyc_q.delete(); err_q.delete();
    endtask

    initial begin
        int exp_src[4];
        logic [31:0] exp_dat[4];
        int n;
        exp_src = '{0, 1, 0, 1};
        exp_dat = '{32'h10, 32'h20, 32'h11, 32'h21};
        cyc = 0; total = 0; bad = 0;
        m_phase = 0; m_grant = 0; m_last = 1; m_errp = 0; m_hold = 0; m_rsp = 0; m_wait_cycles = 0;
        p0 = 0; p1 = 0; pcnt = 0; wcnt = 0; rd_cyc = 0; rsp_cyc = 0; fcr_latched = 0;
        rd_delay = 0; rsp_delay = 0; silent = 0; stray = 0; stall_en = 0; stall_armed = 0;
        rst = 1'b1;
        fcr_cmd_rdreq = 0; fcr_rsp_wrreq = 0; fcr_rsp_data = 0;
        s0_rsp_waitreq = 0; s1_rsp_waitreq = 0;
        drive_fifos();
        repeat (3) tick();
        rst = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_grant", grant, 0);
        chk("rst_err", err_timeout, 0);
        chk("rst_fcr_cmd_waitreq", fcr_cmd_waitreq, 1);
        chk("rst_fcr_rsp_waitreq", fcr_rsp_waitreq, 1);
        chk("rst_rsp_data", s0_rsp_data, 0);
        chk("rst_cmd_data", fcr_cmd_data, 0);

        // Both sources loaded: alternation from reset, minimum-length transactions, stray fcr writes.
        clear_logs();
        stray = 1; rd_delay = 0; rsp_delay = 0;
        q0.push_back(32'hA0A0_0010); q0.push_back(32'hA0A0_0011);
        q1.push_back(32'hB1B1_0020); q1.push_back(32'hB1B1_0021);
        drive_fifos();
        run_idle(200);
        stray = 0;
        chk("rr_write_count", wr_src_q.size(), 4);
        for (int i = 0; i < 4 && i < wr_src_q.size(); i++) begin
            chk("rr_src", wr_src_q[i], exp_src[i]);
            chk("rr_data", wr_data_q[i], exp_dat[i]);
        end
        if (pop_q.size() >= 2) chk("rr_back_to_back", pop_q[1] - pop_q[0], 4);

        // Single s0 command with slow fcr.
        clear_logs();
        rd_delay = 3; rsp_delay = 5;
        q0.push_back({8'h01, 8'h03, 16'd1});
        drive_fifos();
        run_idle(100);
        chk("t1_write_count", wr_src_q.size(), 1);
        if (wr_src_q.size() == 1 && pop_q.size() == 1) begin
            chk("t1_src", wr_src_q[0], 0);
            chk("t1_data", wr_data_q[0], 32'h0000_0001);
            chk("t1_latency", wr_cyc_q[0] - pop_q[0], 11);
        end

        // Silent fcr: timeout word.
        clear_logs();
        silent = 1; rd_delay = 1;
        q0.push_back(32'hC0C0_0033);
        drive_fifos();
        run_idle(100);
        silent = 0;
        chk("t3_err_count", err_q.size(), 1);
        chk("t3_write_count", wr_src_q.size(), 1);
        if (err_q.size() == 1 && wr_src_q.size() == 1) begin
            chk("t3_err_time", err_q[0] - rd_cyc, 17);
            chk("t3_data", wr_data_q[0], 32'hF001_0000);
            chk("t3_src", wr_src_q[0], 0);
            chk("t3_write_time", wr_cyc_q[0], err_q[0]);
        end
        chk("t3_idle", busy, 0);

        // s1 response FIFO full for 20 cycles of delivery.
        clear_logs();
        stall_en = 1; rd_delay = 2; rsp_delay = 4;
        s1_rsp_waitreq = 1;
        q1.push_back(32'hD1D1_0044);
        drive_fifos();
        run_idle(100);
        chk("t4_write_count", wr_src_q.size(), 1);
        if (wr_src_q.size() == 1) begin
            chk("t4_src", wr_src_q[0], 1);
            chk("t4_data", wr_data_q[0], 32'h44);
            chk("t4_write_time", wr_cyc_q[0] - rsp_cyc, 21);
        end

        // Response in the final waiting cycle beats the timeout.
        clear_logs();
        rd_delay = 0; rsp_delay = TMO - 1;
        q0.push_back(32'hE0E0_0055);
        drive_fifos();
        run_idle(100);
        chk("t5_err_count", err_q.size(), 0);
        chk("t5_write_count", wr_src_q.size(), 1);
        chk("t5_rsp_time", rsp_cyc - rd_cyc, 16);
        if (wr_src_q.size() == 1) begin
            chk("t5_data", wr_data_q[0], 32'h55);
            chk("t5_write_time", wr_cyc_q[0] - rsp_cyc, 1);
        end

        // Reset while awaiting reply abandons the transaction.
        clear_logs();
        silent = 1; rd_delay = 0;
        q0.push_back(32'hF0F0_0066);
        drive_fifos();
        n = 0;
        while (fcr_rsp_waitreq && n < 20) begin
            tick();
            n++;
        end
        chk("t6_wait_entry_bound", n < 20, 1);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_busy", busy, 0);
        chk("t6_grant", grant, 0);
        chk("t6_err", err_timeout, 0);
        chk("t6_fcr_cmd_waitreq", fcr_cmd_waitreq, 1);
        chk("t6_fcr_rsp_waitreq", fcr_rsp_waitreq, 1);
        chk("t6_wrreq", {s0_rsp_wrreq, s1_rsp_wrreq, s0_cmd_rdreq, s1_cmd_rdreq}, 0);
        chk("t6_rsp_data", s0_rsp_data, 0);
        silent = 0; rsp_delay = 2;
        q1.push_back(32'h1111_0077);
        drive_fifos();
        run_idle(100);
        chk("t6_write_count", wr_src_q.size(), 1);
        if (wr_src_q.size() == 1) begin
            chk("t6_src", wr_src_q[0], 1);
            chk("t6_data", wr_data_q[0], 32'h77);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
